// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin share of one iterative CORDIC engine between two
// angle requesters, with angle normalisation and a finished-pulse watchdog.
module cordic_arbiter #(
  parameter int ANGLE_W = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 31
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req0_i,
  input  logic                      req1_i,
  input  logic [ANGLE_W-1:0]        angle0_i,
  input  logic [ANGLE_W-1:0]        angle1_i,
  output logic                      ack0_o,
  output logic                      ack1_o,
  output logic                      rsp_valid_o,
  output logic                      rsp_id_o,
  output logic signed [DATA_W-1:0]  rsp_sin_o,
  output logic signed [DATA_W-1:0]  rsp_cos_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      cordic_start_o,
  output logic [ANGLE_W-1:0]        cordic_angle_o,
  input  logic                      cordic_finished_i,
  input  logic signed [DATA_W-1:0]  cordic_sin_i,
  input  logic signed [DATA_W-1:0]  cordic_cos_i
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ANGLE_W-1:0] FULL = ANGLE_W'(36000);
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  logic [1:0]               state_q, state_d;
  logic                     owner_q, last_id_q, rsp_id_q, rsp_err_q;
  logic [7:0]               cnt_q;
  logic [ANGLE_W-1:0]       angle_q;
  logic signed [DATA_W-1:0] sin_q, cos_q;
  logic                     any, gnt1, expired, ending;
  logic [ANGLE_W-1:0]       ang_sel, ang_norm;

  // a tie goes to the requester that was not served last
  assign any      = req0_i | req1_i;
  assign gnt1     = req1_i & (~req0_i | ~last_id_q);
  assign ang_sel  = gnt1 ? angle1_i : angle0_i;
  assign ang_norm = (ang_sel >= FULL) ? ang_sel - FULL : ang_sel;
  assign expired  = cnt_q == CNT_MAX;
  assign ending   = (state_q == S_WAIT) & (cordic_finished_i | expired);

  always_comb begin
    state_d = (state_q == S_IDLE)  ? (any ? S_ISSUE : S_IDLE) :
              (state_q == S_ISSUE) ? S_WAIT :
              (state_q == S_WAIT)  ? (ending ? S_DONE : S_WAIT) : S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_id_q <= 1'b1;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
      angle_q   <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == S_WAIT) ? cnt_q + 8'd1 : '0;
      if (state_q == S_IDLE && any) begin
        owner_q <= gnt1;
        angle_q <= ang_norm;
      end
      // finished wins over the watchdog when both land in the same cycle
      if (ending) begin
        sin_q     <= cordic_finished_i ? cordic_sin_i : '0;
        cos_q     <= cordic_finished_i ? cordic_cos_i : '0;
        rsp_err_q <= ~cordic_finished_i;
        rsp_id_q  <= owner_q;
      end
      if (state_q == S_DONE) last_id_q <= owner_q;
    end
  end

  assign busy_o         = state_q != S_IDLE;
  assign cordic_start_o = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign cordic_angle_o = angle_q;
  assign rsp_valid_o    = state_q == S_DONE;
  assign ack0_o         = (state_q == S_DONE) & ~owner_q;
  assign ack1_o         = (state_q == S_DONE) & owner_q;
  assign rsp_id_o       = rsp_id_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_sin_o      = sin_q;
  assign rsp_cos_o      = cos_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed vectors for the CORDIC arbiter with hand-computed expectations.
module tb_cordic_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0 = 0, req1 = 0;
  logic [15:0] angle0 = 0, angle1 = 0;
  logic ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, cordic_start;
  logic signed [7:0] rsp_sin, rsp_cos;
  logic [15:0] cordic_angle;
  logic cordic_finished = 0;
  logic signed [7:0] cordic_sin = 0, cordic_cos = 0;
  int errs = 0, checks = 0;
  int n;

  always #5 clk = ~clk;

  cordic_arbiter #(.ANGLE_W(16), .DATA_W(8), .TIMEOUT(31)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .angle0_i(angle0), .angle1_i(angle1),
    .ack0_o(ack0), .ack1_o(ack1), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
    .rsp_sin_o(rsp_sin), .rsp_cos_o(rsp_cos), .rsp_err_o(rsp_err), .busy_o(busy),
    .cordic_start_o(cordic_start), .cordic_angle_o(cordic_angle),
    .cordic_finished_i(cordic_finished), .cordic_sin_i(cordic_sin), .cordic_cos_i(cordic_cos)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_start(output int lows);
    lows = 0;
    @(negedge clk);
    while (!cordic_start && lows < 50) begin
      lows++;
      @(negedge clk);
    end
    chk("start_seen", int'(cordic_start), 1);
  endtask

  task automatic fin(input int cyc, input int s, input int c);
    repeat (cyc) @(negedge clk);
    cordic_finished = 1;
    cordic_sin = 8'(s);
    cordic_cos = 8'(c);
    @(negedge clk);
    cordic_finished = 0;
  endtask

  task automatic norm(input int a, input int exp);
    req1 = 1;
    angle1 = 16'(a);
    wait_start(n);
    chk("norm_angle", int'(cordic_angle), exp);
    fin(3, 1, 2);
    chk("norm_ack1", int'(ack1), 1);
    chk("norm_id", int'(rsp_id), 1);
    req1 = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(cordic_start), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_acks", int'({ack0, ack1}), 0);
    chk("rst_sin", int'(rsp_sin), 0);
    chk("rst_angle", int'(cordic_angle), 0);
    rst_n = 1;
    @(negedge clk);
    req0 = 1;
    angle0 = 9000;
    wait_start(n);
    chk("t1_issue_lat", n, 0);
    chk("t1_angle", int'(cordic_angle), 9000);
    chk("t1_busy", int'(busy), 1);
    repeat (12) @(negedge clk);
    chk("t1_wait_start", int'(cordic_start), 1);
    chk("t1_early_valid", int'(rsp_valid), 0);
    cordic_finished = 1;
    cordic_sin = 127;
    cordic_cos = 0;
    @(negedge clk);
    cordic_finished = 0;
    chk("t1_valid", int'(rsp_valid), 1);
    chk("t1_ack0", int'(ack0), 1);
    chk("t1_ack1", int'(ack1), 0);
    chk("t1_id", int'(rsp_id), 0);
    chk("t1_sin", int'(rsp_sin), 127);
    chk("t1_cos", int'(rsp_cos), 0);
    chk("t1_err", int'(rsp_err), 0);
    chk("t1_done_start", int'(cordic_start), 0);
    req0 = 0;
    @(negedge clk);
    chk("t1_idle", int'(busy), 0);
    chk("t1_valid_pulse", int'(rsp_valid), 0);
    chk("t1_sin_hold", int'(rsp_sin), 127);
    norm(45000, 9000);
    norm(36000, 0);
    norm(35999, 35999);
    rst_n = 0;
    req0 = 1; req1 = 1; angle0 = 100; angle1 = 200;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      wait_start(n);
      if (i > 0) chk("gap_low", n + 1, 2);
      chk("rr_angle", int'(cordic_angle), (i % 2) ? 200 : 100);
      fin(2, 16 + i, -100);
      chk("rr_id", int'(rsp_id), i % 2);
      chk("rr_acks", int'({ack1, ack0}), (i % 2) ? 2 : 1);
      chk("rr_cos", int'(rsp_cos), -100);
    end
    wait_start(n);
    repeat (6) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mr_start", int'(cordic_start), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_acks", int'({ack0, ack1, rsp_valid}), 0);
    chk("mr_sin", int'(rsp_sin), 0);
    @(negedge clk);
    rst_n = 1;
    wait_start(n);
    chk("mr_first", int'(cordic_angle), 100);
    fin(2, 34, 0);
    chk("mr_ack0", int'(ack0), 1);
    req0 = 0;
    wait_start(n);
    chk("mr_second", int'(cordic_angle), 200);
    fin(2, 51, 7);
    chk("mr_ack1", int'(ack1), 1);
    chk("mr_sin2", int'(rsp_sin), 51);
    req1 = 0;
    @(negedge clk);
    req0 = 1;
    angle0 = 500;
    wait_start(n);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, 32);
    chk("to_err", int'(rsp_err), 1);
    chk("to_sin", int'(rsp_sin), 0);
    chk("to_cos", int'(rsp_cos), 0);
    chk("to_ack0", int'(ack0), 1);
    req0 = 0;
    @(negedge clk);
    chk("to_idle", int'(busy), 0);
    cordic_finished = 1;
    cordic_sin = 99;
    cordic_cos = 99;
    @(negedge clk);
    cordic_finished = 0;
    chk("ign_busy", int'(busy), 0);
    chk("ign_valid", int'(rsp_valid), 0);
    chk("ign_sin", int'(rsp_sin), 0);
    @(negedge clk);
    chk("ign_valid2", int'(rsp_valid), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
